i2s_master: RTL and testbench

- I2S bus master: generates bclk/lrclk from the system clock, serializes stereo DAC samples onto sdata_o and deserializes ADC samples from sdata_i.
- It is the clock-owning end of the link that i2s_serdes serves as slave.
- Uses: drives codecs configured as I2S slaves, and acts as the codec-side bench model for i2s_serdes.
- Stereo samples travel on Axis_If (DWIDTH = 2*SAMPLE_WIDTH): [47:24] left, [23:0] right.

---
 rtl/i2s_pkg.sv | 22 ++
 rtl/i2s_clkgen.sv | 74 +++++++
 rtl/i2s_master.sv | 209 ++++++++++++++++++++
 tb/tb_i2s_master.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S master: default sample and slot widths, the
// stereo sample layout ({left, right}, left in the upper half) and the
// channel encoding that matches the lrclk level (0 = left, 1 = right).
// ---------------------------------------------------------------------------
package i2s_pkg;

    localparam int I2S_SAMPLE_WIDTH = 24;
    localparam int I2S_SLOT_WIDTH   = 32;

    typedef struct packed {
        logic [I2S_SAMPLE_WIDTH-1:0] left;
        logic [I2S_SAMPLE_WIDTH-1:0] right;
    } stereo_sample_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } channel_e;

endpackage

// File: rtl/i2s_clkgen.sv
// ---------------------------------------------------------------------------
// i2s_clkgen
// Divides the system clock into bclk and tracks the bit position inside the
// stereo frame.
//
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   bclk           bit clock (idles high out of reset)
//   lrclk          word select, 0 = left slot, 1 = right slot
//   fall_stb       high for the clk cycle whose edge makes bclk fall
//   rise_stb       high for the clk cycle whose edge makes bclk rise
//   bit_cnt        current bit position in the frame (0 .. 2*SLOT_WIDTH-1)
//   bit_cnt_next   position bit_cnt takes at the coming fall
// ---------------------------------------------------------------------------
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int BCLK_HALF_PERIOD = 16,
    parameter int SLOT_WIDTH       = I2S_SLOT_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset_n,
    output logic                              bclk,
    output logic                              lrclk,
    output logic                              fall_stb,
    output logic                              rise_stb,
    output logic [$clog2(2*SLOT_WIDTH)-1:0]   bit_cnt,
    output logic [$clog2(2*SLOT_WIDTH)-1:0]   bit_cnt_next
);

    localparam int DIV_W = $clog2(BCLK_HALF_PERIOD);
    localparam int BCW   = $clog2(2*SLOT_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF_PERIOD-1);
    localparam logic [BCW-1:0]   BIT_LAST = BCW'(2*SLOT_WIDTH-1);
    localparam logic [BCW-1:0]   SLOT_C   = BCW'(SLOT_WIDTH);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    logic             lrclk_q, lrclk_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic             term;

    always_comb begin
        term         = (div_cnt_q == DIV_LAST);
        div_cnt_d    = term ? '0 : div_cnt_q + 1'b1;
        bclk_d       = term ? ~bclk_q : bclk_q;
        // Strobes are combinational so that the datapath registers update on
        // the same clk edge that flips bclk.
        fall_stb     = term && bclk_q;
        rise_stb     = term && !bclk_q;
        bit_cnt_next = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
        bit_cnt_d    = fall_stb ? bit_cnt_next : bit_cnt_q;
        lrclk_d      = fall_stb ? (bit_cnt_next >= SLOT_C) : lrclk_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b1;
            lrclk_q   <= 1'b1;
            bit_cnt_q <= BIT_LAST;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            lrclk_q   <= lrclk_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bclk    = bclk_q;
    assign lrclk   = lrclk_q;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/i2s_master.sv
// ---------------------------------------------------------------------------
// i2s_master
// Clock-owning end of an I2S link. Generates bclk/lrclk, shifts stereo DAC
// samples out on sdata_o and collects stereo ADC samples from sdata_i.
//
// Ports:
//   clk, reset_n                  system clock, asynchronous active-low reset
//   tx_sample_data/valid/ready    stereo samples to send, {left, right}
//   rx_sample_data/valid/ready    received stereo samples, {left, right}
//   bclk, lrclk, sdata_o          I2S outputs (lrclk 0 = left)
//   sdata_i                       I2S input, already synchronous to clk
//   clear_status                  one-cycle pulse clearing the sticky flags
//   underrun                      sticky: frame started with no tx sample held
//   overrun                       sticky: rx sample replaced before consumed
//
// Build option I2S_LOOPBACK_EN: the receiver samples the sdata_o register
// instead of sdata_i (sdata_i is then ignored).
// ---------------------------------------------------------------------------
module i2s_master
    import i2s_pkg::*;
#(
    parameter int BCLK_HALF_PERIOD = 16,
    parameter int SAMPLE_WIDTH     = I2S_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH       = I2S_SLOT_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [2*SAMPLE_WIDTH-1:0] tx_sample_data,
    input  logic                      tx_sample_valid,
    output logic                      tx_sample_ready,
    output logic [2*SAMPLE_WIDTH-1:0] rx_sample_data,
    output logic                      rx_sample_valid,
    input  logic                      rx_sample_ready,
    output logic                      bclk,
    output logic                      lrclk,
    output logic                      sdata_o,
    input  logic                      sdata_i,
    input  logic                      clear_status,
    output logic                      underrun,
    output logic                      overrun
);

    localparam int DW  = 2*SAMPLE_WIDTH;
    localparam int BCW = $clog2(2*SLOT_WIDTH);
    localparam logic [BCW-1:0] SLOT_C    = BCW'(SLOT_WIDTH);
    localparam logic [BCW-1:0] SW_C      = BCW'(SAMPLE_WIDTH);
    localparam logic [BCW-1:0] LAST_RX_C = BCW'(SLOT_WIDTH + SAMPLE_WIDTH);

    logic           fall_stb, rise_stb;
    logic [BCW-1:0] bit_cnt, bit_cnt_next;

    i2s_clkgen #(
        .BCLK_HALF_PERIOD (BCLK_HALF_PERIOD),
        .SLOT_WIDTH       (SLOT_WIDTH)
    ) u_clkgen (
        .clk          (clk),
        .reset_n      (reset_n),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .fall_stb     (fall_stb),
        .rise_stb     (rise_stb),
        .bit_cnt      (bit_cnt),
        .bit_cnt_next (bit_cnt_next)
    );

    // Position inside the current slot; 0 is the one-bclk I2S delay bit.
    function automatic logic [BCW-1:0] slot_pos(input logic [BCW-1:0] n);
        return (n >= SLOT_C) ? n - SLOT_C : n;
    endfunction

    function automatic channel_e slot_chan(input logic [BCW-1:0] n);
        return (n >= SLOT_C) ? RIGHT : LEFT;
    endfunction

    function automatic logic in_sample(input logic [BCW-1:0] k);
        return (k >= BCW'(1)) && (k <= SW_C);
    endfunction

    // Bit carried at slot position k (MSB at k = 1); 0 outside the sample.
    function automatic logic pick_bit(input logic [SAMPLE_WIDTH-1:0] word,
                                      input logic [BCW-1:0]          k);
        logic b;
        b = 1'b0;
        for (int i = 0; i < SAMPLE_WIDTH; i++) begin
            if (in_sample(k) && (BCW'(i) == SW_C - k)) begin
                b = word[i];
            end
        end
        return b;
    endfunction

    logic [DW-1:0] hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic [DW-1:0] tx_shift_q, tx_shift_d;
    logic          sdata_q, sdata_d;
    logic [DW-1:0] rx_shift_q, rx_shift_d;
    logic [DW-1:0] rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          underrun_q, underrun_d;
    logic          overrun_q, overrun_d;

    logic                    rx_bit;
    logic                    frame_start, present, tx_xfer;
    logic                    underrun_set, overrun_set;
    logic [BCW-1:0]          k_fall, k_rise;
    channel_e                ch_fall, ch_rise;
    logic [SAMPLE_WIDTH-1:0] tx_word;

`ifdef I2S_LOOPBACK_EN
    logic unused_sdata_i;
    assign unused_sdata_i = sdata_i;
    assign rx_bit         = sdata_q;
`else
    assign rx_bit = sdata_i;
`endif

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_shift_d  = tx_shift_q;
        sdata_d     = sdata_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;

        tx_xfer      = tx_sample_valid && !hold_full_q;
        frame_start  = fall_stb && (bit_cnt_next == '0);
        underrun_set = frame_start && !hold_full_q;

        // Frame start drains the hold register before a same-cycle transfer
        // refills it.
        if (frame_start) begin
            tx_shift_d  = hold_full_q ? hold_q : '0;
            hold_full_d = 1'b0;
        end
        if (tx_xfer) begin
            hold_d      = tx_sample_data;
            hold_full_d = 1'b1;
        end

        k_fall  = slot_pos(bit_cnt_next);
        ch_fall = slot_chan(bit_cnt_next);
        tx_word = (ch_fall == LEFT) ? tx_shift_q[DW-1:SAMPLE_WIDTH]
                                    : tx_shift_q[SAMPLE_WIDTH-1:0];
        if (fall_stb) begin
            sdata_d = pick_bit(tx_word, k_fall);
        end

        k_rise  = slot_pos(bit_cnt);
        ch_rise = slot_chan(bit_cnt);
        if (rise_stb && in_sample(k_rise)) begin
            for (int i = 0; i < SAMPLE_WIDTH; i++) begin
                if (BCW'(i) == SW_C - k_rise) begin
                    if (ch_rise == LEFT) begin
                        rx_shift_d[SAMPLE_WIDTH+i] = rx_bit;
                    end else begin
                        rx_shift_d[i] = rx_bit;
                    end
                end
            end
        end

        // The last right bit lands in rx_shift_d this cycle, so the
        // presented word is taken from the next-state value.
        present     = rise_stb && (bit_cnt == LAST_RX_C);
        overrun_set = present && rx_valid_q && !rx_sample_ready;
        if (present) begin
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
        end else if (rx_valid_q && rx_sample_ready) begin
            rx_valid_d = 1'b0;
        end

        underrun_d = underrun_set ? 1'b1 : (clear_status ? 1'b0 : underrun_q);
        overrun_d  = overrun_set  ? 1'b1 : (clear_status ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_shift_q  <= '0;
            sdata_q     <= 1'b0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_shift_q  <= tx_shift_d;
            sdata_q     <= sdata_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            overrun_q   <= overrun_d;
        end
    end

    assign tx_sample_ready = !hold_full_q;
    assign rx_sample_data  = rx_data_q;
    assign rx_sample_valid = rx_valid_q;
    assign sdata_o         = sdata_q;
    assign underrun        = underrun_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_i2s_master.sv
// ---------------------------------------------------------------------------
// tb_i2s_master
// Bench for i2s_master with BCLK_HALF_PERIOD = 4 (512 clk per frame). The
// reference model works from the edge count since reset release: bclk falls
// at edge 4+8m (bit m of the run), rises at edge 8+8m, and each frame is 64
// bits. Frame words come from a queue of accepted tx samples; rx words come
// from the table the bench serialises onto sdata_i.
// ---------------------------------------------------------------------------
module tb_i2s_master;

    localparam int HALF  = 4;
    localparam int SW    = 24;
    localparam int SLOT  = 32;
    localparam int FBITS = 2*SLOT;

    logic        clk;
    logic        reset_n;
    logic [47:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [47:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        bclk, lrclk, sdata_o, sdata_i;
    logic        clear_status;
    logic        underrun, overrun;

    i2s_master #(
        .BCLK_HALF_PERIOD (HALF),
        .SAMPLE_WIDTH     (SW),
        .SLOT_WIDTH       (SLOT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .tx_sample_data  (tx_data),
        .tx_sample_valid (tx_valid),
        .tx_sample_ready (tx_ready),
        .rx_sample_data  (rx_data),
        .rx_sample_valid (rx_valid),
        .rx_sample_ready (rx_ready),
        .bclk            (bclk),
        .lrclk           (lrclk),
        .sdata_o         (sdata_o),
        .sdata_i         (sdata_i),
        .clear_status    (clear_status),
        .underrun        (underrun),
        .overrun         (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          p;
    logic [47:0] txq[$];
    logic [47:0] cur_tx;
    logic        m_valid, m_und, m_ovr, last_acc;
    logic [47:0] m_data;
    logic [47:0] rxw[16];

    // I2S bit n of a frame carrying word w: MSB one bclk after the slot edge.
    function automatic logic chan_bit(input logic [47:0] w, input int n);
        int          k;
        logic [47:0] sh;
        k = n % SLOT;
        if (k < 1 || k > SW) return 1'b0;
        sh = (n >= SLOT) ? (w >> (SW - k)) : (w >> (2*SW - k));
        return sh[0];
    endfunction

    task automatic model_reset();
        p = 0;
        txq.delete();
        cur_tx   = '0;
        m_valid  = 1'b0;
        m_data   = '0;
        m_und    = 1'b0;
        m_ovr    = 1'b0;
        last_acc = 1'b0;
    endtask

    task automatic model_step();
        logic acc, cons, set_u, set_o;
        int   m;
        acc   = tx_valid && (txq.size() == 0);
        cons  = m_valid && rx_ready;
        set_u = 1'b0;
        set_o = 1'b0;
        p++;
        if (p >= 4 && (p - 4) % 8 == 0) begin
            m = (p - 4) / 8;
            if (m % FBITS == 0) begin
                if (txq.size() > 0) cur_tx = txq.pop_front();
                else begin
                    cur_tx = '0;
                    set_u  = 1'b1;
                end
            end
        end
        if (p >= 8 && (p - 8) % 8 == 0 && ((p - 8) / 8) % FBITS == SLOT + SW) begin
            m = (p - 8) / 8;
            if (m_valid && !rx_ready) set_o = 1'b1;
`ifdef I2S_LOOPBACK_EN
            m_data = cur_tx;
`else
            m_data = rxw[(m / FBITS) % 16];
`endif
            m_valid = 1'b1;
        end else if (cons) begin
            m_valid = 1'b0;
        end
        if (acc) txq.push_back(tx_data);
        last_acc = acc;
        m_und = set_u ? 1'b1 : (clear_status ? 1'b0 : m_und);
        m_ovr = set_o ? 1'b1 : (clear_status ? 1'b0 : m_ovr);
    endtask

    task automatic check_outputs();
        int   m, n;
        logic eb, el, es, er;
        eb = ((p / 4) % 2) == 0;
        if (p < 4) begin
            el = 1'b1;
            es = 1'b0;
        end else begin
            m  = (p - 4) / 8;
            n  = m % FBITS;
            el = (n >= SLOT);
            es = chan_bit(cur_tx, n);
        end
        er = (txq.size() == 0);
        check_eq("bclk",     64'(bclk),     64'(eb));
        check_eq("lrclk",    64'(lrclk),    64'(el));
        check_eq("sdata_o",  64'(sdata_o),  64'(es));
        check_eq("tx_ready", 64'(tx_ready), 64'(er));
        check_eq("rx_valid", 64'(rx_valid), 64'(m_valid));
        check_eq("rx_data",  64'(rx_data),  64'(m_data));
        check_eq("underrun", 64'(underrun), 64'(m_und));
        check_eq("overrun",  64'(overrun),  64'(m_ovr));
    endtask

    // Codec side: change sdata_i after each bclk fall, random outside samples.
    task automatic drive_sdata_i();
        int m, n, k;
        sdata_i = ($urandom_range(0, 1) != 0);
`ifndef I2S_LOOPBACK_EN
        if (p >= 4) begin
            m = (p - 4) / 8;
            n = m % FBITS;
            k = n % SLOT;
            if (k >= 1 && k <= SW) sdata_i = chan_bit(rxw[(m / FBITS) % 16], n);
        end
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    // Hold reset, check reset state, then release on a falling edge.
    task automatic begin_phase();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        drive_sdata_i();
        reset_n = 1'b1;
    endtask

    task automatic rand_word(output logic [47:0] w);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        w = r[47:0];
    endtask

    initial begin
        int guard;
        reset_n      = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = '0;
        rx_ready     = 1'b1;
        clear_status = 1'b0;
        sdata_i      = 1'b0;
        for (int i = 0; i < 16; i++) rand_word(rxw[i]);

        // Phase 1: continuous tx stream, known rx word in frame 0.
        rxw[0]   = 48'h123456_FEDCBA;
        tx_valid = 1'b1;
        tx_data  = 48'hA5A5A5_5A5A5A;
        rx_ready = 1'b1;
        begin_phase();
        repeat (1100) begin
            step();
            drive_sdata_i();
        end

        // Phase 2: no tx, rx never consumed, clear pulses mid-run.
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        rand_word(rxw[0]);
        begin_phase();
        repeat (1100) begin
            step();
            clear_status = (p == 699) || (p == 1049);
            drive_sdata_i();
        end
        clear_status = 1'b0;

        // Phase 3: sparse random tx, random rx stalls and clears.
        for (int i = 0; i < 16; i++) rand_word(rxw[i]);
        tx_valid = 1'b1;
        tx_data  = 48'h000001_800000;
        rx_ready = 1'b1;
        begin_phase();
        repeat (2700) begin
            step();
            if (!tx_valid || last_acc) begin
                tx_valid = ($urandom_range(0, 599) == 0);
                if (tx_valid) rand_word(tx_data);
            end
            if ($urandom_range(0, 399) == 0) rx_ready = !rx_ready;
            clear_status = ($urandom_range(0, 499) == 0);
            drive_sdata_i();
        end
        clear_status = 1'b0;

        // Phase 4: reset at bit 40 of the second frame, then a clean frame.
        rand_word(tx_data);
        tx_valid = 1'b1;
        rx_ready = 1'b0;
        begin_phase();
        guard = 0;
        while (p < 512 + 324 && guard < 3000) begin
            step();
            drive_sdata_i();
            guard++;
        end
        check_eq("reach_bit40", 64'(p), 64'(512 + 324));
        reset_n = 1'b0;
        #1;
        check_eq("rst_bclk",     64'(bclk),     64'd1);
        check_eq("rst_lrclk",    64'(lrclk),    64'd1);
        check_eq("rst_rx_valid", 64'(rx_valid), 64'd0);
        check_eq("rst_sdata_o",  64'(sdata_o),  64'd0);
        rxw[0]   = 48'h5C3A96_0F1E2D;
        rx_ready = 1'b1;
        begin_phase();
        repeat (700) begin
            step();
            drive_sdata_i();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
